// File: rtl/ppu_pkg.sv
// Shared constants and the palette index mirroring function for the PPU palette writer.
// Note: the toggle enum lives here so the top and any future bench model agree on w encoding.
package ppu_pkg;

  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam logic [5:0] PAL_BASE = 6'h3F;
  localparam int         PAL_W    = 6;

  typedef enum logic {
    WTOG_HIGH = 1'b0,
    WTOG_LOW  = 1'b1
  } wtog_e;

  // $3F10/14/18/1C fold onto $3F00/04/08/0C.
  function automatic logic [4:0] pidx(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

endpackage

// File: rtl/palette_ram32x6.sv
// 32 x 6 palette storage: synchronous write, combinational renderer read, async clear.
// With PAL_RD_EN a second combinational read port feeds the CPU PPUDATA read path.
module palette_ram32x6
  import ppu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [4:0]       i_waddr,
  input  logic [PAL_W-1:0] i_wdata,
  input  logic [4:0]       i_raddr,
  output logic [PAL_W-1:0] o_rdata
`ifdef PAL_RD_EN
  ,
  input  logic [4:0]       i_raddr_cpu,
  output logic [PAL_W-1:0] o_rdata_cpu
`endif
);

  logic [PAL_W-1:0] r_mem [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef PAL_RD_EN
  assign o_rdata_cpu = r_mem[i_raddr_cpu];
`endif

endmodule

// File: rtl/ppu_palette_writer.sv
// PPUADDR/PPUDATA decode feeding the palette RAM; renderer reads through a ROM-compatible port.
// Optional macro PAL_RD_EN builds the CPU PPUDATA palette read path and cpu_dout register.
//
// state     | meaning
// WTOG_HIGH | next PPUADDR write is the high byte
// WTOG_LOW  | next PPUADDR write is the low byte
module ppu_palette_writer
  import ppu_pkg::*;
#(
  parameter logic INC_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  reg_sel,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [7:0]  cpu_din,
  input  logic        inc32,
  output logic [7:0]  cpu_dout,
  output logic [13:0] vram_addr,
  output logic        ext_we,
  input  logic [4:0]  addr,
  output logic [7:0]  dout
);

  logic [13:0]      r_vaddr;
  logic [5:0]       r_t_hi;
  wtog_e            r_wtog;
  wtog_e            w_wtog_next;
  logic             r_ext_we;

  logic             w_we_addr;
  logic             w_we_data;
  logic             w_re_stat;
  logic             w_re_data;
  logic             w_data_acc;
  logic             w_in_pal;
  logic             w_inc32;
  logic [13:0]      w_v_inc;
  logic             w_t_load;
  logic             w_v_load;
  logic             w_ram_we;
  logic [PAL_W-1:0] w_rdata;

  assign w_we_addr = cpu_we && (reg_sel == REG_ADDR);
  assign w_we_data = cpu_we && (reg_sel == REG_DATA);
  // A simultaneous write strobe wins; the read is dropped.
  assign w_re_stat = cpu_re && !cpu_we && (reg_sel == REG_STATUS);
  assign w_in_pal  = (r_vaddr[13:8] == PAL_BASE);

  // INC_DEFAULT=1 forces the +32 stride for integrations with no PPUCTRL driving inc32.
  assign w_inc32    = inc32 | INC_DEFAULT;
  assign w_v_inc    = r_vaddr + (w_inc32 ? 14'd32 : 14'd1);
  assign w_data_acc = w_we_data | w_re_data;
  assign w_ram_we   = w_we_data && w_in_pal;

  always_comb begin
    w_wtog_next = r_wtog;
    w_t_load    = 1'b0;
    w_v_load    = 1'b0;
    if (w_we_addr) begin
      if (r_wtog == WTOG_HIGH) begin
        w_wtog_next = WTOG_LOW;
        w_t_load    = 1'b1;
      end else begin
        w_wtog_next = WTOG_HIGH;
        w_v_load    = 1'b1;
      end
    end else if (w_re_stat) begin
      w_wtog_next = WTOG_HIGH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wtog <= WTOG_HIGH;
    end else begin
      r_wtog <= w_wtog_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vaddr  <= '0;
      r_t_hi   <= '0;
      r_ext_we <= 1'b0;
    end else begin
      r_ext_we <= w_we_data && !w_in_pal;
      if (w_t_load) r_t_hi <= cpu_din[5:0];
      if (w_v_load) begin
        r_vaddr <= {r_t_hi, cpu_din};
      end else if (w_data_acc) begin
        r_vaddr <= w_v_inc;
      end
    end
  end

`ifdef PAL_RD_EN
  logic [PAL_W-1:0] w_rdata_cpu;
  logic [7:0]       r_cpu_dout;

  assign w_re_data = cpu_re && !cpu_we && (reg_sel == REG_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_dout <= '0;
    end else if (w_re_data && w_in_pal) begin
      r_cpu_dout <= {2'b00, w_rdata_cpu};
    end
  end

  assign cpu_dout = r_cpu_dout;

  palette_ram32x6 u_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_ram_we),
    .i_waddr     (pidx(r_vaddr[4:0])),
    .i_wdata     (cpu_din[5:0]),
    .i_raddr     (pidx(addr)),
    .o_rdata     (w_rdata),
    .i_raddr_cpu (pidx(r_vaddr[4:0])),
    .o_rdata_cpu (w_rdata_cpu)
  );
`else
  logic w_unused_re;

  assign w_re_data   = 1'b0;
  assign w_unused_re = cpu_re;
  assign cpu_dout    = '0;

  palette_ram32x6 u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_waddr (pidx(r_vaddr[4:0])),
    .i_wdata (cpu_din[5:0]),
    .i_raddr (pidx(addr)),
    .o_rdata (w_rdata)
  );
`endif

  assign vram_addr = r_vaddr;
  assign ext_we    = r_ext_we;
  assign dout      = {2'b00, w_rdata};

endmodule

// File: tb/tb_ppu_palette_writer.sv
// Self-checking bench for ppu_palette_writer: directed vector table, corner sequences, random ops vs a model.
module tb_ppu_palette_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  reg_sel;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_din;
  logic        inc32;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic        ext_we;
  logic [4:0]  addr;
  logic [7:0]  dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ppu_palette_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_sel   (reg_sel),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_din   (cpu_din),
    .inc32     (inc32),
    .cpu_dout  (cpu_dout),
    .vram_addr (vram_addr),
    .ext_we    (ext_we),
    .addr      (addr),
    .dout      (dout)
  );

  // Reference model: plain integers and an array indexed by the mirrored entry.
  int m_pal [32];
  int m_v, m_t, m_w, m_cdout, m_ext;
  bit rd_en;

  function automatic int m_idx(input int a);
    if (a >= 16 && (a % 4) == 0) return a - 16;
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pal[i] = 0;
    m_v = 0; m_t = 0; m_w = 0; m_cdout = 0; m_ext = 0;
  endtask

  task automatic model_step(input int sel, input bit we, input bit re, input int din, input bit inc);
    int step;
    step  = inc ? 32 : 1;
    m_ext = 0;
    if (we) begin
      if (sel == 6) begin
        if (m_w == 0) begin m_t = din % 64; m_w = 1; end
        else begin m_v = m_t * 256 + din; m_w = 0; end
      end else if (sel == 7) begin
        if (m_v / 256 == 63) m_pal[m_idx(m_v % 32)] = din % 64;
        else m_ext = 1;
        m_v = (m_v + step) % 16384;
      end
    end else if (re) begin
      if (sel == 2) m_w = 0;
      else if (sel == 7 && rd_en) begin
        if (m_v / 256 == 63) m_cdout = m_pal[m_idx(m_v % 32)];
        m_v = (m_v + step) % 16384;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input int sel, input bit we, input bit re, input int din, input bit inc, input int raddr);
    @(negedge clk);
    reg_sel = sel[2:0];
    cpu_we  = we;
    cpu_re  = re;
    cpu_din = din[7:0];
    inc32   = inc;
    addr    = raddr[4:0];
    model_step(sel, we, re, din, inc);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  typedef struct {
    int sel; bit we; bit re; int din; bit inc; int raddr;
    int exp_v; int exp_dout; bit exp_ext;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int sel, input bit we, input bit re, input int din, input bit inc,
                     input int raddr, input int ev, input int ed, input bit ee);
    vec_t v;
    v.sel = sel; v.we = we; v.re = re; v.din = din; v.inc = inc; v.raddr = raddr;
    v.exp_v = ev; v.exp_dout = ed; v.exp_ext = ee;
    tbl.push_back(v);
  endtask

  initial begin
`ifdef PAL_RD_EN
    rd_en = 1'b1;
`else
    rd_en = 1'b0;
`endif
    rst_n = 1'b0; reg_sel = '0; cpu_we = 0; cpu_re = 0; cpu_din = '0; inc32 = 0; addr = '0;
    model_reset();

    //   sel we re din   inc raddr vaddr    dout ext
    add(6, 1, 0, 'h3F, 0, 0,  'h0000, 'h00, 0);
    add(6, 1, 0, 'h00, 0, 0,  'h3F00, 'h00, 0);
    add(7, 1, 0, 'h15, 0, 0,  'h3F01, 'h15, 0);
    add(7, 1, 0, 'h2D, 0, 1,  'h3F02, 'h2D, 0);
    add(7, 1, 0, 'h27, 0, 2,  'h3F03, 'h27, 0);
    add(7, 1, 0, 'h30, 0, 3,  'h3F04, 'h30, 0);
    add(6, 1, 0, 'h3F, 0, 0,  'h3F04, 'h15, 0);
    add(2, 0, 1, 'h00, 0, 1,  'h3F04, 'h2D, 0);
    add(6, 1, 0, 'h3F, 0, 0,  'h3F04, 'h15, 0);
    add(6, 1, 0, 'h10, 0, 0,  'h3F10, 'h15, 0);
    add(7, 1, 0, 'h21, 0, 0,  'h3F11, 'h21, 0);
    add(0, 1, 0, 'h55, 0, 16, 'h3F11, 'h21, 0);
    add(3, 1, 0, 'h77, 0, 1,  'h3F11, 'h2D, 0);
    add(6, 1, 0, 'h3F, 0, 1,  'h3F11, 'h2D, 0);
    add(6, 1, 0, 'h01, 0, 1,  'h3F01, 'h2D, 0);
    add(7, 1, 0, 'hFF, 0, 1,  'h3F02, 'h3F, 0);
    add(6, 1, 0, 'h3F, 0, 0,  'h3F02, 'h21, 0);
    add(6, 1, 0, 'h1F, 0, 0,  'h3F1F, 'h21, 0);
    add(7, 1, 0, 'h0A, 0, 31, 'h3F20, 'h0A, 0);
    add(6, 1, 0, 'h3F, 0, 0,  'h3F20, 'h21, 0);
    add(6, 1, 0, 'hF0, 0, 0,  'h3FF0, 'h21, 0);
    add(7, 1, 0, 'h0B, 1, 16, 'h0010, 'h0B, 0);
    add(6, 1, 0, 'h20, 0, 0,  'h0010, 'h0B, 0);
    add(6, 1, 0, 'h00, 0, 0,  'h2000, 'h0B, 0);
    add(7, 1, 0, 'hAA, 0, 3,  'h2001, 'h30, 1);
    add(0, 0, 0, 'h00, 0, 0,  'h2001, 'h0B, 0);

    repeat (2) @(negedge clk);
    #1;
    check("rst_vaddr", vram_addr, 0);
    check("rst_ext_we", ext_we, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_dout", dout, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].sel, tbl[i].we, tbl[i].re, tbl[i].din, tbl[i].inc, tbl[i].raddr);
      check($sformatf("tbl%0d_vaddr", i), vram_addr, tbl[i].exp_v);
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("tbl%0d_ext_we", i), ext_we, tbl[i].exp_ext);
    end

    // PPUDATA read of $3F03 (or its absence in the default build).
    do_op(6, 1, 0, 'h3F, 0, 3);
    do_op(6, 1, 0, 'h03, 0, 3);
    do_op(7, 0, 1, 'h00, 0, 3);
    check("rd_cpu_dout", cpu_dout, rd_en ? 'h30 : 0);
    check("rd_vaddr", vram_addr, rd_en ? 'h3F04 : 'h3F03);

    // Write and read strobed together: the write wins, no read data captured.
    do_op(6, 1, 0, 'h3F, 0, 5);
    do_op(6, 1, 0, 'h05, 0, 5);
    do_op(7, 1, 1, 'h12, 0, 5);
    check("wr_rd_dout", dout, 'h12);
    check("wr_rd_vaddr", vram_addr, 'h3F06);
    check("wr_rd_cpu_dout", cpu_dout, rd_en ? 'h30 : 0);

    // Async reset right after an external write and a dangling high byte.
    do_op(6, 1, 0, 'h20, 0, 0);
    do_op(6, 1, 0, 'h00, 0, 0);
    do_op(6, 1, 0, 'h05, 0, 0);
    do_op(7, 1, 0, 'hAA, 0, 3);
    check("pre_rst_ext_we", ext_we, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_ext_we", ext_we, 0);
    check("async_rst_vaddr", vram_addr, 0);
    check("async_rst_dout", dout, 0);
    check("async_rst_cpu_dout", cpu_dout, 0);
    @(negedge clk) rst_n = 1'b1;
    do_op(6, 1, 0, 'h3F, 0, 0);
    do_op(6, 1, 0, 'h02, 0, 0);
    check("post_rst_vaddr", vram_addr, 'h3F02);

    for (int k = 0; k < 400; k++) begin
      int sel, din, ra;
      bit we, re, inc;
      case ($urandom_range(0, 9))
        0, 1, 2: sel = 6;
        3, 4, 5, 6: sel = 7;
        7: sel = 2;
        default: sel = $urandom_range(0, 7);
      endcase
      we  = $urandom_range(0, 2) != 0;
      re  = $urandom_range(0, 2) == 0;
      din = $urandom_range(0, 255);
      if (sel == 6 && m_w == 0 && $urandom_range(0, 3) != 0) din = 'h3F;
      inc = $urandom_range(0, 3) == 0;
      ra  = $urandom_range(0, 31);
      do_op(sel, we, re, din, inc, ra);
      check("rnd_vaddr", vram_addr, m_v);
      check("rnd_ext_we", ext_we, m_ext);
      check("rnd_dout", dout, m_pal[m_idx(ra)]);
      check("rnd_cpu_dout", cpu_dout, m_cdout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_palette_writer.md
# ppu_palette_writer

CPU-facing writer for the NES PPU palette memory: decodes PPUADDR ($2006) and PPUDATA ($2007) accesses and writes 6-bit colour indices into a 32-entry palette RAM. The renderer reads the same RAM through a combinational port that is drop-in compatible with the fixed palette ROMs (5-bit `addr`, 8-bit `dout`). It sits between the CPU register decode and the pixel mux, replacing a per-game palette ROM when the game loads its palette at run time.

## Interface
- `INC_DEFAULT`, 1'b0: increment select used while `inc32` is not driven by PPUCTRL logic; 0 = +1, 1 = +32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `reg_sel`  in  3  PPU register index (CPU A[2:0]); 6 = PPUADDR, 7 = PPUDATA, 2 = PPUSTATUS.
- `cpu_we`  in  1  one-cycle write strobe for the register at `reg_sel`.
- `cpu_re`  in  1  one-cycle read strobe for the register at `reg_sel`.
- `cpu_din`  in  8  CPU write data.
- `inc32`  in  1  PPUCTRL bit 2; address increment after a PPUDATA access: 0 = +1, 1 = +32.
- `cpu_dout`  out  8  PPUDATA read data (palette region only); registered.
- `vram_addr`  out  14  current PPU address (v register).
- `ext_we`  out  1  one-cycle pulse: PPUDATA write outside $3F00-$3FFF, forwarded to the VRAM/CHR path.
- `addr`  in  5  renderer palette address.
- `dout`  out  8  renderer palette data, combinational, bits [7:6] always 0.

## Operation
- Storage: 32 x 6 bits. Index mapping `pidx(a)`: if a[4]=1 and a[1:0]=0, use {1'b0, a[3:0]}; otherwise a[4:0]. $3F10/14/18/1C alias $3F00/04/08/0C for both write and read.
- Write toggle `w`: 0 = expecting high byte, 1 = expecting low byte.
- PPUADDR write, w=0: t[13:8] <= cpu_din[5:0]; w <= 1.
- PPUADDR write, w=1: vram_addr <= {t[13:8], cpu_din}; w <= 0.
- PPUSTATUS read: w <= 0. All other PPUSTATUS behaviour lives elsewhere.
- PPUDATA write: if vram_addr[13:8] = 6'h3F, RAM[pidx(vram_addr[4:0])] <= cpu_din[5:0]; else ext_we pulses for one cycle. vram_addr then increments by 1 or 32 per `inc32`, modulo 2^14 (wraps $3FFF -> $0000).
- PPUDATA read (with PAL_RD_EN): if in palette region, cpu_dout <= {2'b00, RAM[pidx]}; vram_addr increments as for writes. Outside the palette region, cpu_dout is unchanged.
- Renderer port: dout = {2'b00, RAM[pidx(addr)]}. Mirroring applies to this port too.
- `cpu_we` and `cpu_re` asserted together: the write takes effect and the read is ignored.
- `reg_sel` values other than 2, 6 and 7 are ignored.

## Timing
- Reset (async assert): vram_addr=0, t=0, w=0, cpu_dout=0, ext_we=0, RAM=0 (see Configuration). Deassertion is synchronous to `clk` upstream.
- PPUDATA write at edge N: the new value is visible on `dout` after edge N. vram_addr holds the incremented value after edge N.
- PPUDATA read: cpu_dout is valid after the strobe edge (one-cycle latency). There is no buffered-read delay for the palette region.
- Back-to-back PPUDATA strobes on consecutive cycles are supported. Each one uses the address already incremented by the previous one.
- Reset asserted between the two PPUADDR writes: w returns to 0, so the next write is treated as a high byte.

## Configuration
- `PAL_RD_EN` defined: the PPUDATA palette read path and `cpu_dout` register are built.
- `PAL_RD_EN` undefined: `cpu_dout` is tied to 0, PPUDATA reads do not increment vram_addr, and RAM is write-only from the CPU side.

## Structure
- Shared package `ppu_pkg`: register index constants (REG_STATUS=2, REG_ADDR=6, REG_DATA=7), PAL_BASE=6'h3F, the palette entry width (6), and the `pidx` mapping function.
- One sub-module: `palette_ram32x6`, with one synchronous write port, one combinational read port, and async clear.

## Test plan
- Reset, then write $3F,$00 to PPUADDR, then write $15,$2D,$27,$30 to PPUDATA with inc32=0 -> dout at addr 0..3 = $15,$2D,$27,$30; vram_addr=$3F04.
- Write a PPUDATA value to $3F10, then set addr=0 -> dout=$21. Set addr=5'h10 -> dout=$21.
- Write $FF to $3F01 -> dout at addr 1 = $3F; bits [7:6] = 0.
- Write $3F to PPUADDR, read PPUSTATUS, then write $3F,$1F to PPUADDR -> vram_addr=$3F1F. A further PPUDATA write wraps vram_addr to $3F20 with inc32=0. With inc32=1 from $3FF0, vram_addr wraps to $0010.
- Set PPUADDR=$2000, write PPUDATA=$AA -> ext_we high for exactly 1 cycle, palette unchanged, vram_addr=$2001.
- (PAL_RD_EN) Set PPUADDR=$3F03, pulse cpu_re on PPUDATA -> cpu_dout=$30 on the next cycle, vram_addr=$3F04. Assert rst_n low mid-sequence -> all outputs 0 immediately.
